// File: rtl/word_loader.sv
// Buffers words from the serial receiver and writes them to consecutive memory addresses.
// The processor is held in reset until the terminator word has been consumed.
module word_loader #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [11:0] BASE_ADDR = 12'h000,
    parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        word_ready,
    input  logic [31:0] word_in,
    input  logic        mem_stall,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    typedef enum logic {
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_s1;
    logic        r_s2;
    logic        r_s3;

    logic [31:0] r_fifo [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0] r_count;

    logic [11:0] r_addr;
    logic        r_overflow;

    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic        w_loading;
    logic        w_pop;
    logic [31:0] w_head;
    logic        w_head_end;
    logic        w_finish;
    logic        w_accept;
    logic        w_drop;
    logic        w_write;

    // word_ready may be asynchronous; s3 only serves edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= word_ready;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_comb begin
        w_push     = r_s2 & ~r_s3;
        w_full     = (r_count == FULL_COUNT);
        w_empty    = (r_count == '0);
        w_loading  = (r_state == ST_LOAD);
        w_head     = r_fifo[r_rptr];
        w_head_end = (w_head == END_WORD);
        w_pop      = ~w_empty & ~mem_stall & w_loading;
        w_finish   = w_pop & w_head_end;
        w_write    = w_pop & ~w_head_end;
        // a full FIFO still takes a push when the head leaves on the same edge
        w_accept   = w_push & w_loading & (~w_full | w_pop);
        w_drop     = w_push & w_loading & w_full & ~w_pop;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_wptr] <= word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_finish) begin
            // anything still queued behind the terminator is discarded
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= BASE_ADDR;
        end else if (w_write) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_finish) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_DONE;
            default: w_state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        cpu_hold = 1'b1;
        done     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                cpu_hold = 1'b1;
                done     = 1'b0;
            end
            ST_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            default: begin
                cpu_hold = 1'b1;
                done     = 1'b0;
            end
        endcase
        mem_we   = w_write;
        mem_addr = r_addr;
        mem_data = w_head;
        overflow = r_overflow;
    end

endmodule

// File: tb/tb_word_loader.sv
// Self-checking bench for word_loader: two instances (base 000 and FFE) share stimulus
// and are compared every cycle against a queue-based model, plus directed literal checks.
module tb_word_loader;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] END_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        word_ready = 1'b0;
    logic [31:0] word_in = '0;
    logic        mem_stall = 1'b0;

    logic        we_a, we_b;
    logic [11:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        hold_a, hold_b;
    logic        done_a, done_b;
    logic        ovf_a, ovf_b;

    always #5 clk = ~clk;

    word_loader #(.DEPTH(DEPTH), .BASE_ADDR(12'h000), .END_WORD(END_W)) u_a (
        .clk(clk), .reset(reset), .word_ready(word_ready), .word_in(word_in),
        .mem_stall(mem_stall), .mem_we(we_a), .mem_addr(addr_a), .mem_data(data_a),
        .cpu_hold(hold_a), .done(done_a), .overflow(ovf_a)
    );

    word_loader #(.DEPTH(DEPTH), .BASE_ADDR(12'hFFE), .END_WORD(END_W)) u_b (
        .clk(clk), .reset(reset), .word_ready(word_ready), .word_in(word_in),
        .mem_stall(mem_stall), .mem_we(we_b), .mem_addr(addr_b), .mem_data(data_b),
        .cpu_hold(hold_b), .done(done_b), .overflow(ovf_b)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: queue of buffered words, write address per instance, flags
    logic [31:0] mq[$];
    logic        m_done = 1'b0;
    logic        m_ovf = 1'b0;
    logic [11:0] m_addr[2];
    logic [2:0]  m_sync = '0;
    bit          m_valid = 1'b0;
    int unsigned cyc = 0;
    bit          rand_stall = 1'b0;

    logic [11:0] la_addr[$];
    logic [31:0] la_data[$];
    int unsigned la_cyc[$];
    logic [11:0] lb_addr[$];

    always @(posedge clk) begin
        bit push, pop, acc, drop;
        logic [31:0] w;
        cyc++;
        if (reset) begin
            mq.delete();
            m_done    = 1'b0;
            m_ovf     = 1'b0;
            m_addr[0] = 12'h000;
            m_addr[1] = 12'hFFE;
            m_sync    = '0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            push = m_sync[1] & ~m_sync[2];
            pop  = !m_done && (mq.size() > 0) && !mem_stall;
            acc  = push && !m_done && ((mq.size() < DEPTH) || pop);
            drop = push && !m_done && !acc;
            if (pop) begin
                w = mq.pop_front();
                if (w == END_W) begin
                    m_done = 1'b1;
                    mq.delete();
                    acc = 1'b0;
                end else begin
                    m_addr[0] = m_addr[0] + 12'd1;
                    m_addr[1] = m_addr[1] + 12'd1;
                end
            end
            if (acc) mq.push_back(word_in);
            if (drop) m_ovf = 1'b1;
            m_sync = {m_sync[1:0], word_ready};
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic exp_we;
            exp_we = !m_done && (mq.size() > 0) && !mem_stall && (mq[0] != END_W);
            chk("mem_we_a", {31'd0, we_a}, {31'd0, exp_we});
            chk("mem_we_b", {31'd0, we_b}, {31'd0, exp_we});
            chk("mem_addr_a", {20'd0, addr_a}, {20'd0, m_addr[0]});
            chk("mem_addr_b", {20'd0, addr_b}, {20'd0, m_addr[1]});
            chk("cpu_hold_a", {31'd0, hold_a}, {31'd0, !m_done});
            chk("cpu_hold_b", {31'd0, hold_b}, {31'd0, !m_done});
            chk("done_a", {31'd0, done_a}, {31'd0, m_done});
            chk("done_b", {31'd0, done_b}, {31'd0, m_done});
            chk("overflow_a", {31'd0, ovf_a}, {31'd0, m_ovf});
            chk("overflow_b", {31'd0, ovf_b}, {31'd0, m_ovf});
            if (!m_done && mq.size() > 0) begin
                chk("mem_data_a", data_a, mq[0]);
                chk("mem_data_b", data_b, mq[0]);
            end
            if (we_a === 1'b1) begin
                la_addr.push_back(addr_a);
                la_data.push_back(data_a);
                la_cyc.push_back(cyc);
            end
            if (we_b === 1'b1) lb_addr.push_back(addr_b);
        end
    end

    always @(posedge clk) begin
        if (rand_stall) begin
            #2;
            mem_stall = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        la_addr.delete();
        la_data.delete();
        la_cyc.delete();
        lb_addr.delete();
    endtask

    task automatic do_reset();
        word_ready = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic send(input logic [31:0] w, input int hi, input int lo);
        word_in = w;
        word_ready = 1'b1;
        tick(hi);
        word_ready = 1'b0;
        tick(lo);
    endtask

    task automatic chk_log_a(input string name, input int idx, input logic [11:0] a, input logic [31:0] d);
        chk({name, "_addr"}, {20'd0, la_addr[idx]}, {20'd0, a});
        chk({name, "_data"}, la_data[idx], d);
    endtask

    logic [31:0] words[5];

    initial begin
        words[0] = 32'h1111_0001;
        words[1] = 32'h2222_0002;
        words[2] = 32'h3333_0003;
        words[3] = 32'h4444_0004;
        words[4] = 32'h5555_0005;

        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("rst_cpu_hold", {31'd0, hold_a}, 32'd1);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_overflow", {31'd0, ovf_a}, 32'd0);
        chk("rst_mem_we", {31'd0, we_a}, 32'd0);
        chk("rst_addr_a", {20'd0, addr_a}, 32'h000);
        chk("rst_addr_b", {20'd0, addr_b}, 32'hFFE);

        // basic load with terminator and its latency
        clear_logs();
        send(32'h0000_0013, 4, 2);
        send(32'h00A0_0093, 4, 2);
        word_in = END_W;
        word_ready = 1'b1;
        tick(3);
        chk("end_not_yet_done", {31'd0, done_a}, 32'd0);
        tick(1);
        chk("end_done", {31'd0, done_a}, 32'd1);
        chk("end_cpu_hold", {31'd0, hold_a}, 32'd0);
        word_ready = 1'b0;
        tick(3);
        chk("basic_nwrites", la_addr.size(), 32'd2);
        chk_log_a("basic_w0", 0, 12'h000, 32'h0000_0013);
        chk_log_a("basic_w1", 1, 12'h001, 32'h00A0_0093);

        // four words under stall, then drain back-to-back
        do_reset();
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) send(words[i], 4, 2);
        chk("stall4_nowrite", la_addr.size(), 32'd0);
        mem_stall = 1'b0;
        tick(8);
        chk("stall4_nwrites", la_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk_log_a("stall4", i, 12'(i), words[i]);
            chk("stall4_addr_b", {20'd0, lb_addr[i]}, {20'd0, 12'hFFE + 12'(i)});
        end
        for (int i = 1; i < 4; i++) chk("stall4_b2b", la_cyc[i], la_cyc[i-1] + 1);
        chk("stall4_overflow", {31'd0, ovf_a}, 32'd0);

        // five words under stall: the fifth is dropped
        do_reset();
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) send(words[i], 4, 2);
        chk("ovf_before", {31'd0, ovf_a}, 32'd0);
        send(words[4], 4, 2);
        chk("ovf_after", {31'd0, ovf_a}, 32'd1);
        mem_stall = 1'b0;
        tick(8);
        chk("ovf_nwrites", la_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk_log_a("ovf", i, 12'(i), words[i]);

        // address wrap on the FFE instance
        do_reset();
        for (int i = 0; i < 3; i++) send(words[i], 4, 2);
        send(END_W, 4, 2);
        chk("wrap_nwrites", lb_addr.size(), 32'd3);
        chk("wrap_a0", {20'd0, lb_addr[0]}, 32'hFFE);
        chk("wrap_a1", {20'd0, lb_addr[1]}, 32'hFFF);
        chk("wrap_a2", {20'd0, lb_addr[2]}, 32'h000);
        chk("wrap_done", {31'd0, done_b}, 32'd1);

        // reset with words buffered under stall
        do_reset();
        mem_stall = 1'b1;
        send(words[0], 4, 2);
        send(words[1], 4, 2);
        reset = 1'b1;
        tick(1);
        chk("midrst_addr_a", {20'd0, addr_a}, 32'h000);
        chk("midrst_addr_b", {20'd0, addr_b}, 32'hFFE);
        chk("midrst_cpu_hold", {31'd0, hold_a}, 32'd1);
        reset = 1'b0;
        mem_stall = 1'b0;
        tick(8);
        chk("midrst_nwrites", la_addr.size(), 32'd0);

        // words after DONE are ignored
        do_reset();
        send(32'h0000_0013, 4, 2);
        send(END_W, 4, 2);
        send(32'h1234_5678, 4, 4);
        chk("postdone_nwrites", la_addr.size(), 32'd1);
        chk("postdone_overflow", {31'd0, ovf_a}, 32'd0);
        chk("postdone_done", {31'd0, done_a}, 32'd1);

        // randomized traffic with random stalls, checked by the model
        rand_stall = 1'b1;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 25; i++) begin
                logic [31:0] w;
                w = $urandom();
                if ($urandom_range(0, 19) == 0) w = END_W;
                word_in = w;
                word_ready = 1'b1;
                tick($urandom_range(3, 5));
                word_ready = 1'b0;
                word_in = $urandom();
                tick($urandom_range(1, 4));
            end
        end
        rand_stall = 1'b0;
        tick(1);
        mem_stall = 1'b0;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/word_loader.md
# word_loader

Downstream consumer of the serial word receiver. Takes each assembled 32-bit word flagged by the receiver's `ready` level and buffers it in a small FIFO. Writes the buffered words to sequential instruction/data memory addresses, and holds the processor in reset until a terminator word arrives. Memory back-pressure (`mem_stall`) is absorbed by the FIFO, so words arriving during a stall are not lost.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `BASE_ADDR`, 12'h000: first memory address written after reset.
- `END_WORD`, 32'hFFFF_FFFF: terminator value; ends the load and is never written to memory.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `word_ready` input 1: receiver word-valid level, possibly asynchronous to `clk`; high for ≥3 `clk` cycles per word.
- `word_in` input 32: receiver output word; stable while `word_ready` is high.
- `mem_stall` input 1: memory cannot accept a write this cycle.
- `mem_we` output 1: memory write enable, one cycle per word.
- `mem_addr` output 12: write address.
- `mem_data` output 32: write data, equal to the FIFO head.
- `cpu_hold` output 1: keeps the processor in reset while loading.
- `done` output 1: terminator consumed; load complete.
- `overflow` output 1: sticky; a word was dropped because the FIFO was full.

## Operation
- Synchronizer: `word_ready` passes through flops s1 and s2; s3 is s2 delayed one cycle. `push` = s2 & ~s3, i.e. a single push per rising edge. `word_in` is captured into the FIFO tail on the push edge.
- FIFO: circular buffer of DEPTH×32 with read/write pointers and a (log2(DEPTH)+1)-bit count. `full` is count==DEPTH; `empty` is count==0.
- FSM has two states:
  - LOAD, entered on reset: `cpu_hold`=1, `done`=0.
  - DONE: `cpu_hold`=0, `done`=1. DONE is left only by `reset`.
- `pop` = !empty & !mem_stall & state==LOAD.
  - If the head ≠ END_WORD: `mem_we`=1 (combinational), `mem_data`=head, `mem_addr`=address counter. The counter increments after the write.
  - If the head == END_WORD: `mem_we`=0, the entry is popped, and the FSM moves to DONE on that edge.
- Address counter is 12 bits, wraps 12'hFFF→12'h000, and is unaffected by stalls.
- Push while full and not popping in the same cycle: the word is dropped, `overflow` sets, and FIFO contents are unchanged. Push while full with a simultaneous pop is accepted and count is unchanged.
- In DONE, pushes are ignored (no FIFO write, no `overflow`). Remaining FIFO entries are discarded.
- `mem_stall` high: no pop and `mem_we`=0. `mem_addr` and `mem_data` stay at the head and counter values.

## Timing
- Reset values:
  - `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_data`=FIFO head (don't-care, because the FIFO is empty).
  - `cpu_hold`=1, `done`=0, `overflow`=0.
  - FIFO empty; s1, s2 and s3 = 0.
- Reset asserted mid-load: all of the above apply on the next edge. Buffered words are lost.
- Latency when `word_ready` rises before edge k and there is no stall:
  - s1=1 after edge k; s2=1 after edge k+1.
  - The push writes the FIFO on edge k+2.
  - `mem_we`=1 during cycle k+2→k+3, and the write commits on edge k+3.
- Throughput: one memory write per cycle while the FIFO is non-empty and `mem_stall` is low.
- Terminator: `cpu_hold` falls and `done` rises on the edge that pops END_WORD, 3 edges after its `word_ready` edge when unstalled.

## Test plan
- Reset, then send words 0x00000013, 0x00A00093, 0xFFFFFFFF.
  - Required: writes at 0x000 and 0x001, with `mem_we` high for exactly 2 cycles.
  - `done`=1 and `cpu_hold`=0 three edges after the third `word_ready` rise.
- Hold `mem_stall`=1 and send 4 words (with DEPTH=4), then release.
  - Required: 4 back-to-back writes at consecutive addresses, data in arrival order, `overflow`=0.
- Hold `mem_stall`=1 and send 5 words.
  - Required: `overflow`=1 after the 5th push edge, the 5th word is not written, and the first 4 are written in order after release.
- Set BASE_ADDR=12'hFFE and send 3 data words plus END_WORD.
  - Required: addresses FFE, FFF, 000.
- Raise `reset` with 2 words buffered under a stall.
  - Required: the next cycle shows FIFO empty, `mem_addr`=BASE_ADDR, `cpu_hold`=1, and no `mem_we` after the stall drops.
- After DONE, send 0x12345678.
  - Required: `mem_we` stays 0, `overflow` stays 0, `done` stays 1.
